// File: rtl/packed_das_beamformer_if.sv
// Stream interface for packed_das_beamformer.
// Input side: NUM_CH packed signed samples with valid/ready.
// Output side: beam sum with valid/ready plus the data-good qualifier
// (and sat_flag when PACKED_DAS_SAT_EN is defined).
// Modports: slave = beamformer, master = the source/sink driving it.
interface packed_das_beamformer_if #(
  parameter int NUM_CH   = 3,
  parameter int SAMPLE_W = 31
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OUT_W = SAMPLE_W + CH_W;

  logic [NUM_CH*SAMPLE_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [OUT_W-1:0]           out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_good;
`ifdef PACKED_DAS_SAT_EN
  logic                       sat_flag;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_good, sat_flag
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_good, sat_flag
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_good
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_good
  );
`endif
endinterface

// File: rtl/packed_das_beamformer.sv
// Parametrised delay-and-sum beamformer.
// Each accepted packed word is written into NUM_CH circular delay lines.
// A channel-slice FSM then sums the delayed samples one channel per cycle
// and holds the result on a valid/ready output.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        stream interface (in_data/in_valid/in_ready,
//              out_data/out_valid/out_ready/out_good[/sat_flag])
//   cfg_we     delay write strobe
//   cfg_ch     channel to configure
//   cfg_delay  delay in samples
//   cfg_err    one-cycle pulse for a rejected config write
// Optional feature macro: PACKED_DAS_SAT_EN saturates the sum to the
// SAMPLE_W signed range and adds bus.sat_flag.
module packed_das_beamformer #(
  parameter  int NUM_CH   = 3,
  parameter  int SAMPLE_W = 31,
  parameter  int DEPTH    = 64,
  localparam int DLY_W    = $clog2(DEPTH),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OUT_W    = SAMPLE_W + CH_W
) (
  input  logic                         clk,
  input  logic                         rst,
  packed_das_beamformer_if.slave       bus,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [DLY_W-1:0]             cfg_delay,
  output logic                         cfg_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [DLY_W:0]   CNT_MAX  = (DLY_W+1)'(DEPTH);

  state_t state, next_state;

  logic [SAMPLE_W-1:0] mem [NUM_CH][DEPTH];
  logic [DLY_W-1:0]    delay [NUM_CH];
  logic [DLY_W-1:0]    wr_ptr, cur_ptr, rd_idx;
  logic [DLY_W:0]      sample_cnt;
  logic [CH_W-1:0]     ch;
  logic [OUT_W-1:0]    acc, term, sum, final_sum;
  logic [SAMPLE_W-1:0] rd_sample;
  logic                good, term_ok, last_ch, accept, cfg_ok, ready_c;
  logic [OUT_W-1:0]    out_data_r;
  logic                out_valid_r, out_good_r;
  logic                sat_hit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and in_ready; in_ready is also forced low while reset is held
  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = rst;
        if (bus.in_valid && rst) next_state = ACCUM;
      end
      ACCUM: if (last_ch) next_state = HOLD;
      HOLD:  if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign accept  = bus.in_valid & ready_c;
  assign cfg_ok  = (state == IDLE) && ({1'b0, cfg_ch} < NUM_CH_V);
  assign last_ch = (ch == LAST_CH);

  // Read side: index arithmetic wraps naturally at DLY_W bits (DEPTH is a power of two).
  // A term counts only once enough samples have arrived to cover its delay.
  assign rd_idx    = cur_ptr - delay[ch];
  assign rd_sample = mem[ch][rd_idx];
  assign term_ok   = sample_cnt > {1'b0, delay[ch]};
  assign term      = term_ok ? {{CH_W{rd_sample[SAMPLE_W-1]}}, rd_sample} : '0;
  assign sum       = acc + term;

`ifdef PACKED_DAS_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {{(CH_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {{(CH_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  // Clip the full-precision sum into the SAMPLE_W signed range
  always_comb begin
    final_sum = sum;
    sat_hit   = 1'b0;
    if ($signed(sum) > $signed(SAT_MAX)) begin
      final_sum = SAT_MAX;
      sat_hit   = 1'b1;
    end else if ($signed(sum) < $signed(SAT_MIN)) begin
      final_sum = SAT_MIN;
      sat_hit   = 1'b1;
    end
  end

  logic sat_flag_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          sat_flag_r <= 1'b0;
    else if (state == ACCUM && last_ch) sat_flag_r <= sat_hit;
  end

  assign bus.sat_flag = sat_flag_r;
`else
  assign final_sum = sum;
  assign sat_hit   = 1'b0;
`endif

  // Delay-line storage; contents are don't-care after reset so it has none
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[c][wr_ptr] <= bus.in_data[c*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Datapath: pointers, warm-up counter, accumulator, output register, config
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      cur_ptr     <= '0;
      sample_cnt  <= '0;
      ch          <= '0;
      acc         <= '0;
      good        <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_good_r  <= 1'b0;
      cfg_err     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) delay[c] <= '0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok;
      if (cfg_we && cfg_ok) delay[cfg_ch] <= cfg_delay;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_ptr <= wr_ptr;
            wr_ptr  <= wr_ptr + 1'b1;
            if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
            acc     <= '0;
            ch      <= '0;
            good    <= 1'b1;
          end
        end
        ACCUM: begin
          acc <= sum;
          ch  <= ch + 1'b1;
          if (!term_ok) good <= 1'b0;
          if (last_ch) begin
            out_data_r  <= final_sum;
            out_good_r  <= good & term_ok;
            out_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_good  = out_good_r;

endmodule

// File: tb/tb_packed_das_beamformer.sv
// Directed self-checking bench for packed_das_beamformer
// (NUM_CH=3, SAMPLE_W=31, DEPTH=64). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_packed_das_beamformer;

  localparam int NUM_CH   = 3;
  localparam int SAMPLE_W = 31;
  localparam int DEPTH    = 64;
  localparam int TMO      = 50;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [5:0] cfg_delay;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  packed_das_beamformer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

  packed_das_beamformer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_delay (cfg_delay),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something above fails to terminate
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < TMO) begin
      @(negedge clk);
      k++;
    end
    check_output("wait_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < TMO) begin
      @(negedge clk);
      k++;
    end
    check_output("wait_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  // Presents one packed word and returns on the falling edge after accept
  task automatic apply_stimulus(input logic [30:0] s0, input logic [30:0] s1, input logic [30:0] s2);
    wait_ready();
    bus.in_data  = {s2, s1, s0};
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic ramp(input int n);
    apply_stimulus(31'(10*n), 31'(10*n + 1), 31'(10*n + 2));
  endtask

  task automatic get_result(output logic [63:0] d, output logic g);
    wait_valid();
    d = 64'(bus.out_data);
    g = bus.out_good;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [5:0] dly);
    cfg_we    = 1'b1;
    cfg_ch    = c;
    cfg_delay = dly;
    @(negedge clk);
    cfg_we = 1'b0;
    check_output("cfg_err_legal", 64'(cfg_err), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [63:0] d;
  logic        g;

  initial begin
    rst           = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cfg_we        = 1'b0;
    cfg_ch        = '0;
    cfg_delay     = '0;

    // Reset values
    @(negedge clk);
    check_output("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_out_data",  64'(bus.out_data),  64'd0);
    check_output("rst_out_good",  64'(bus.out_good),  64'd0);
    check_output("rst_cfg_err",   64'(cfg_err),       64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Delays 0: (1,2,3) -> 6 exactly three cycles after accept
    apply_stimulus(31'd1, 31'd2, 31'd3);
    check_output("lat_in_ready_1",  64'(bus.in_ready),  64'd0);
    check_output("lat_out_valid_0", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_output("lat_out_valid_1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_output("lat_out_valid_2", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_output("lat_out_valid_3", 64'(bus.out_valid), 64'd1);
    check_output("sum_123",         64'(bus.out_data),  64'd6);
    check_output("good_123",        64'(bus.out_good),  64'd1);
    check_output("hold_in_ready",   64'(bus.in_ready),  64'd0);
`ifdef PACKED_DAS_SAT_EN
    check_output("sat_flag_clear",  64'(bus.sat_flag),  64'd0);
`endif
    get_result(d, g);

    // Delays (0,1,2) with a ramp; first two results miss terms
    do_reset();
    cfg_write(2'd0, 6'd0);
    cfg_write(2'd1, 6'd1);
    cfg_write(2'd2, 6'd2);
    ramp(0);
    get_result(d, g);
    check_output("ramp0_data", d, 64'd0);
    check_output("ramp0_good", 64'(g), 64'd0);
    ramp(1);
    get_result(d, g);
    check_output("ramp1_data", d, 64'd11);
    check_output("ramp1_good", 64'(g), 64'd0);
    for (int n = 2; n <= 5; n++) begin
      ramp(n);
      get_result(d, g);
      check_output("ramp_data", d, 64'(30*n - 27));
      check_output("ramp_good", 64'(g), 64'd1);
    end

    // Backpressure: output held 10 cycles
    ramp(6);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      check_output("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_output("bp_out_data",  64'(bus.out_data),  64'd153);
      check_output("bp_out_good",  64'(bus.out_good),  64'd1);
      check_output("bp_in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_output("bp_valid_drop", 64'(bus.out_valid), 64'd0);
    check_output("bp_ready_rise", 64'(bus.in_ready),  64'd1);

    // Config write during ACCUM is rejected
    wait_ready();
    bus.in_data  = {31'd72, 31'd71, 31'd70};
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cfg_we       = 1'b1;
    cfg_ch       = 2'd0;
    cfg_delay    = 6'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    check_output("cfg_err_accum", 64'(cfg_err), 64'd1);
    @(negedge clk);
    check_output("cfg_err_accum_pulse", 64'(cfg_err), 64'd0);
    get_result(d, g);
    check_output("ramp7_data", d, 64'd183);

    // Config write to a channel that does not exist is rejected
    cfg_we    = 1'b1;
    cfg_ch    = 2'd3;
    cfg_delay = 6'd9;
    @(negedge clk);
    cfg_we = 1'b0;
    check_output("cfg_err_badch", 64'(cfg_err), 64'd1);
    @(negedge clk);
    check_output("cfg_err_badch_pulse", 64'(cfg_err), 64'd0);
    ramp(8);
    get_result(d, g);
    check_output("ramp8_data", d, 64'd213);
    check_output("ramp8_good", 64'(g), 64'd1);

    // Reset during ACCUM discards the partial sum
    apply_stimulus(31'd5, 31'd5, 31'd5);
    rst = 1'b0;
    #1;
    check_output("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("midrst_in_ready",  64'(bus.in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_output("midrst_no_valid", 64'(bus.out_valid), 64'd0);
    check_output("midrst_idle",     64'(bus.in_ready),  64'd1);

    // Pointer wrap with delay[0]=63; channel c of sample n = 100*n+c
    cfg_write(2'd0, 6'd63);
    for (int n = 0; n < 70; n++) begin
      apply_stimulus(31'(100*n), 31'(100*n + 1), 31'(100*n + 2));
      get_result(d, g);
      if (n == 62) check_output("wrap62_good", 64'(g), 64'd0);
      if (n == 63) begin
        check_output("wrap63_data", d, 64'd12603);
        check_output("wrap63_good", 64'(g), 64'd1);
      end
      if (n == 64) check_output("wrap64_data", d, 64'd12903);
      if (n == 69) begin
        check_output("wrap69_data", d, 64'd14403);
        check_output("wrap69_good", 64'(g), 64'd1);
      end
    end

    // Full-scale inputs: saturated or full-precision depending on build
    do_reset();
    apply_stimulus(31'h3FFF_FFFF, 31'h3FFF_FFFF, 31'h3FFF_FFFF);
    wait_valid();
`ifdef PACKED_DAS_SAT_EN
    check_output("sat_pos_data", 64'(bus.out_data), 64'h0_3FFF_FFFF);
    check_output("sat_pos_flag", 64'(bus.sat_flag), 64'd1);
`else
    check_output("full_pos_data", 64'(bus.out_data), 64'h0_BFFF_FFFD);
`endif
    get_result(d, g);
    apply_stimulus(31'h4000_0000, 31'h4000_0000, 31'h4000_0000);
    wait_valid();
`ifdef PACKED_DAS_SAT_EN
    check_output("sat_neg_data", 64'(bus.out_data), 64'h1_C000_0000);
    check_output("sat_neg_flag", 64'(bus.sat_flag), 64'd1);
`else
    check_output("full_neg_data", 64'(bus.out_data), 64'h1_4000_0000);
`endif
    get_result(d, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
